hilo_mult_ctrl: RTL and testbench

Multi-cycle sequencer and HI/LO register pair around the combinational 32x32 multiplier. Captures operands on a start request and drives them to the multiplier, which is treated as a LATENCY-cycle multicycle path. It then writes the 64-bit product into the architectural HI/LO registers. It also services move-to-HI/LO writes and reports BUSY so the datapath control can stall HI/LO reads.

---
 rtl/hilo_mult_ctrl.sv | 136 +++++++++++++
 tb/tb_hilo_mult_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_mult_ctrl
// Brief    : Multi-cycle sequencer and HI/LO register pair around an external
//            combinational 32x32 multiplier, with move-to-HI/LO support.
//            Optional macro HILO_MULT_RESTART_EN lets START in RUN restart.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_mult_ctrl #(
    parameter int LATENCY = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        SIGNED,
    input  logic [31:0] OP_A,
    input  logic [31:0] OP_B,
    input  logic        MTHI,
    input  logic        MTLO,
    input  logic [31:0] WDATA,
    output logic [31:0] MUL_A,
    output logic [31:0] MUL_B,
    output logic        MUL_SIGNED,
    input  logic [31:0] MUL_HI,
    input  logic [31:0] MUL_LO,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_run   = 1'b1;
    localparam logic [4:0] c_cnt_load = 5'(LATENCY - 1);

    logic [0:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic        r_mul_signed;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic [0:0]  w_state_nxt;
    logic [4:0]  w_cnt_nxt;
    logic        w_load;
    logic        w_capture;
    logic        w_restart;
    logic        w_busy;
    logic        w_move_hi;
    logic        w_move_lo;

`ifdef HILO_MULT_RESTART_EN
    assign w_restart = START;
`else
    assign w_restart = 1'b0;
`endif

    // State register and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= c_st_idle;
            r_cnt        <= 5'd0;
            r_mul_a      <= 32'd0;
            r_mul_b      <= 32'd0;
            r_mul_signed <= 1'b0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_capture;
            if (w_load) begin
                r_mul_a      <= OP_A;
                r_mul_b      <= OP_B;
                r_mul_signed <= SIGNED;
            end
            if (w_capture) begin
                r_hi <= MUL_HI;
                r_lo <= MUL_LO;
            end else begin
                if (w_move_hi) r_hi <= WDATA;
                if (w_move_lo) r_lo <= WDATA;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (START) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = c_cnt_load;
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                // A restart discards the in-flight product, even on the capture cycle
                if (w_restart) begin
                    w_load    = 1'b1;
                    w_cnt_nxt = c_cnt_load;
                end else if (r_cnt != 5'd0) begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end else begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Output logic
    always_comb begin
        w_busy    = (r_state == c_st_run);
        w_move_hi = MTHI && !w_busy;
        w_move_lo = MTLO && !w_busy;
    end

    assign MUL_A      = r_mul_a;
    assign MUL_B      = r_mul_b;
    assign MUL_SIGNED = r_mul_signed;
    assign HI         = r_hi;
    assign LO         = r_lo;
    assign BUSY       = w_busy;
    assign DONE       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hilo_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_mult_ctrl
// Brief    : Scoreboard bench for hilo_mult_ctrl with an attached multiplier
//            model; honours HILO_MULT_RESTART_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_mult_ctrl;

    localparam int LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] mul_a, mul_b, mul_hi, mul_lo, hi, lo;
    logic        mul_signed, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_mult_ctrl #(.LATENCY(LATENCY)) dut (
        .CLK(clk), .RST(rst), .START(start), .SIGNED(sgn),
        .OP_A(op_a), .OP_B(op_b), .MTHI(mthi), .MTLO(mtlo), .WDATA(wdata),
        .MUL_A(mul_a), .MUL_B(mul_b), .MUL_SIGNED(mul_signed),
        .MUL_HI(mul_hi), .MUL_LO(mul_lo),
        .HI(hi), .LO(lo), .BUSY(busy), .DONE(done)
    );

    always #5 clk = ~clk;

    // External combinational multiplier
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    assign w_prod_s = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
    assign w_prod_u = {32'd0, mul_a} * {32'd0, mul_b};
    assign {mul_hi, mul_lo} = mul_signed ? w_prod_s : w_prod_u;

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = longint'(a) * longint'(b);
        return s ? 64'(sp) : 64'(up);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural state after each rising edge
    int          m_busy_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic        m_s = 1'b0, m_done = 1'b0;
    logic [63:0] m_pend = '0;
    logic [63:0] sb_q[$];
    bit          started = 0;

    initial forever begin
        @(posedge clk);
        m_done = 1'b0;
        if (rst) begin
            m_busy_left = 0;
            m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_s = 1'b0;
            sb_q.delete();
        end else if (m_busy_left > 0) begin
`ifdef HILO_MULT_RESTART_EN
            if (start) begin
                m_a = op_a; m_b = op_b; m_s = sgn;
                m_pend = ref_prod(sgn, op_a, op_b);
                m_busy_left = LATENCY;
                void'(sb_q.pop_back());
                sb_q.push_back(m_pend);
            end else
`endif
            begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end
        end else begin
            if (mthi) m_hi = wdata;
            if (mtlo) m_lo = wdata;
            if (start) begin
                m_a = op_a; m_b = op_b; m_s = sgn;
                m_pend = ref_prod(sgn, op_a, op_b);
                m_busy_left = LATENCY;
                sb_q.push_back(m_pend);
            end
        end
        started = 1;
    end

    // Monitor: compares every cycle, pops the scoreboard on DONE
    logic [63:0] exp_res;
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("busy", 64'(busy), 64'(m_busy_left > 0));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
            check("mul_a", 64'(mul_a), 64'(m_a));
            check("mul_b", 64'(mul_b), 64'(m_b));
            check("mul_signed", 64'(mul_signed), 64'(m_s));
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_unexpected: got DONE=1 expected no pending product");
                end else begin
                    exp_res = sb_q.pop_front();
                    check("product", {hi, lo}, exp_res);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic st, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic mh, input logic ml, input logic [31:0] wd);
        rst = r; start = st; sgn = s; op_a = a; op_b = b; mthi = mh; mtlo = ml; wdata = wd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic go(input logic s, input logic [31:0] a, input logic [31:0] b);
        drive(1'b0, 1'b1, s, a, b, 1'b0, 1'b0, '0);
    endtask

    initial begin
        @(negedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);

        go(1'b1, 32'hFFFF_FFFD, 32'd5);
        check("signed_busy", 64'(busy), 64'd1);
        idle(LATENCY);
        check("signed_done", 64'(done), 64'd1);
        check("signed_prod", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        go(1'b0, 32'hFFFF_FFFF, 32'd2);
        idle(LATENCY);
        check("unsigned_prod", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1234_5678);
        check("mthi_idle", 64'(hi), 64'h1234_5678);
        go(1'b0, 32'd2, 32'd2);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'hAAAA_5555);
        check("mtlo_busy_ignored", 64'(lo), 64'hFFFF_FFFE);
        idle(LATENCY - 1);
        check("mtlo_then_capture", 64'(lo), 64'd4);

        go(1'b0, 32'd7, 32'd6);
        idle(1);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
        check("rst_midop", {hi, lo, mul_a, mul_b}, 128'd0);
        check("rst_midop_flags", {61'd0, mul_signed, busy, done}, 64'd0);
        go(1'b0, 32'd7, 32'd6);
        idle(LATENCY);
        check("after_rst_prod", {hi, lo}, 64'd42);

        go(1'b0, 32'd2, 32'd2);
        idle(LATENCY);
        check("b2b_first", {63'd0, done}, 64'd1);
        check("b2b_first_lo", 64'(lo), 64'd4);
        go(1'b0, 32'd3, 32'd3);
        idle(LATENCY);
        check("b2b_second_lo", 64'(lo), 64'd9);

        idle(1);
        go(1'b0, 32'd2, 32'd2);
        idle(1);
        go(1'b0, 32'd3, 32'd5);
        idle(LATENCY);
`ifdef HILO_MULT_RESTART_EN
        check("overlap_lo", 64'(lo), 64'd15);
`else
        check("overlap_lo", 64'(lo), 64'd4);
`endif
        idle(2);

        for (int i = 0; i < 800; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'(($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'd0) : $urandom;
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, 1'($urandom),
                  a, b, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom);
        end
        idle(LATENCY + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
